// File: rtl/regfile_pkg.sv
// Shared constants and dump state encoding for the register file slice.
package regfile_pkg;

  localparam int N    = 64;
  localparam int REGS = 32;

  localparam logic [4:0] XZR_IDX = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } dump_state_e;

endpackage

// File: rtl/regfile_dump_ctrl.sv
// Dump sequencer: walks indices 0..31 one beat per accepted handshake, then pulses done.
module regfile_dump_ctrl (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dump_req,
  input  logic                     dump_ready,
  output logic                     dump_valid,
  output logic [4:0]               dump_idx,
  output logic                     dump_done,
  output regfile_pkg::dump_state_e state_o
);
  import regfile_pkg::*;

  dump_state_e state_q, state_d;
  logic [4:0]  idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Handshake: a beat transfers on a rising edge where dump_valid && dump_ready;
  // once raised, dump_valid stays high and dump_idx stays put until that transfer.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dump_valid = 1'b0;
    dump_done  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (dump_req) begin
          state_d = ST_STREAM;
          idx_d   = 5'd0;
        end
      end
      ST_STREAM: begin
        dump_valid = 1'b1;
        if (dump_ready) begin
          if (idx_q == XZR_IDX) state_d = ST_DONE;
          else                  idx_d   = idx_q + 5'd1;
        end
      end
      ST_DONE: begin
        dump_done = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dump_idx = idx_q;
  assign state_o  = state_q;

endmodule

// File: rtl/regfile.sv
// Two-read/one-write register file with hardwired-zero index 31, write-through
// bypass on the read ports, and a handshaked dump stream of all registers.
module regfile #(
  parameter int N    = regfile_pkg::N,
  parameter int REGS = regfile_pkg::REGS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [4:0]               ra1,
  input  logic [4:0]               ra2,
  output logic [N-1:0]             rd1,
  output logic [N-1:0]             rd2,
  input  logic                     we3,
  input  logic [4:0]               wa3,
  input  logic [N-1:0]             wd3,
  input  logic                     dump_req,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [4:0]               dump_idx,
  output logic [N-1:0]             dump_data,
  output logic                     dump_done,
  output regfile_pkg::dump_state_e dbg_state_o
);
  import regfile_pkg::*;

  // Storage covers only the writable registers; index 31 has no flop.
  logic [N-1:0] regs_q [REGS-1];
  logic         wr_en;

  assign wr_en = we3 && (wa3 != XZR_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REGS - 1; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wa3] <= wd3;
    end
  end

  always_comb begin
    rd1 = '0;
    if (ra1 != XZR_IDX) rd1 = (wr_en && wa3 == ra1) ? wd3 : regs_q[ra1];
  end

  always_comb begin
    rd2 = '0;
    if (ra2 != XZR_IDX) rd2 = (wr_en && wa3 == ra2) ? wd3 : regs_q[ra2];
  end

  // Dump shows committed contents only, so a write appears one cycle later.
  always_comb begin
    dump_data = '0;
    if (dump_idx != XZR_IDX) dump_data = regs_q[dump_idx];
  end

  regfile_dump_ctrl u_dump_ctrl (
    .clk        (clk),
    .reset      (reset),
    .dump_req   (dump_req),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_idx   (dump_idx),
    .dump_done  (dump_done),
    .state_o    (dbg_state_o)
  );

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: reset, read/write/bypass, XZR, dump streaming and abort.
module tb_regfile;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  ra1 = '0, ra2 = '0, wa3 = '0;
  logic [63:0] rd1, rd2, wd3 = '0, dump_data;
  logic        we3 = 1'b0, dump_req = 1'b0, dump_ready = 1'b0;
  logic        dump_valid, dump_done;
  logic [4:0]  dump_idx;
  dump_state_e dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile dut (
    .clk        (clk),
    .reset      (reset),
    .ra1        (ra1),
    .ra2        (ra2),
    .rd1        (rd1),
    .rd2        (rd2),
    .we3        (we3),
    .wa3        (wa3),
    .wd3        (wd3),
    .dump_req   (dump_req),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .dump_done  (dump_done),
    .dbg_state_o(dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_times_three();
    for (int i = 0; i < 31; i++) begin
      we3 = 1'b1; wa3 = 5'(i); wd3 = 64'(i * 3);
      tick();
    end
    we3 = 1'b0;
  endtask

  task automatic start_dump();
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    #1;
    n_tests++;
    if (dump_valid !== 1'b1 || dump_idx !== 5'd0) begin
      n_fail++;
      $display("FAIL start_dump: valid=%b idx=%0d, required valid=1 idx=0", dump_valid, dump_idx);
    end
  endtask

  task automatic go_to_idx(input logic [4:0] target);
    int cyc = 0;
    while (!(dump_valid === 1'b1 && dump_idx === target) && cyc < 40) begin
      tick();
      cyc++;
    end
    n_tests++;
    if (cyc >= 40) begin
      n_fail++;
      $display("FAIL go_to_idx: idx=%0d after 40 cycles, required %0d", dump_idx, target);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; we3 = 1'b1; wa3 = 5'd3; wd3 = '1; dump_req = 1'b1;
    repeat (5) tick();
    reset = 1'b0; we3 = 1'b0; dump_req = 1'b0;
    #1;
    n_tests++;
    if (dbg_state !== ST_IDLE || dump_valid !== 1'b0 || dump_done !== 1'b0 || dump_idx !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: state=%0d valid=%b done=%b idx=%0d, required 0/0/0/0",
               dbg_state, dump_valid, dump_done, dump_idx);
    end
    for (int a = 0; a < 31; a++) begin
      ra1 = 5'(a);
      #1;
      n_tests++;
      if (rd1 !== 64'd0) begin
        n_fail++;
        $display("FAIL reset_reg[%0d]: rd1=%h, required 0", a, rd1);
      end
    end
  endtask

  task automatic test_write_read();
    we3 = 1'b1; wa3 = 5'd5; wd3 = 64'hDEAD_BEEF_0000_0001; ra1 = 5'd5; ra2 = 5'd6;
    #1;
    n_tests++;
    if (rd1 !== 64'hDEAD_BEEF_0000_0001) begin
      n_fail++;
      $display("FAIL bypass_rd1: rd1=%h, required deadbeef00000001", rd1);
    end
    n_tests++;
    if (rd2 !== 64'd0) begin
      n_fail++;
      $display("FAIL bypass_other_port: rd2=%h, required 0", rd2);
    end
    tick();
    we3 = 1'b0; wd3 = '0; ra2 = 5'd5;
    #1;
    n_tests++;
    if (rd1 !== 64'hDEAD_BEEF_0000_0001 || rd2 !== 64'hDEAD_BEEF_0000_0001) begin
      n_fail++;
      $display("FAIL persist_x5: rd1=%h rd2=%h, required deadbeef00000001", rd1, rd2);
    end
  endtask

  task automatic test_xzr();
    we3 = 1'b1; wa3 = 5'd31; wd3 = 64'hFFFF_FFFF_FFFF_FFFF; ra2 = 5'd31; ra1 = 5'd5;
    #1;
    n_tests++;
    if (rd2 !== 64'd0) begin
      n_fail++;
      $display("FAIL xzr_same_cycle: rd2=%h, required 0", rd2);
    end
    tick();
    we3 = 1'b0;
    #1;
    n_tests++;
    if (rd2 !== 64'd0 || rd1 !== 64'hDEAD_BEEF_0000_0001) begin
      n_fail++;
      $display("FAIL xzr_next_cycle: rd2=%h rd1=%h, required 0 and deadbeef00000001", rd2, rd1);
    end
  endtask

  task automatic test_full_dump();
    logic [63:0] exp;
    fill_times_three();
    dump_ready = 1'b1;
    start_dump();
    for (int b = 0; b < 32; b++) begin
      exp = (b == 31) ? 64'd0 : 64'(b * 3);
      n_tests++;
      if (dump_valid !== 1'b1 || dump_idx !== 5'(b) || dump_data !== exp || dump_done !== 1'b0) begin
        n_fail++;
        $display("FAIL dump_beat[%0d]: valid=%b idx=%0d data=%h done=%b, required 1/%0d/%h/0",
                 b, dump_valid, dump_idx, dump_data, dump_done, b, exp);
      end
      dump_req = (b >= 5 && b <= 8);
      tick();
    end
    dump_req = 1'b0;
    n_tests++;
    if (dump_done !== 1'b1 || dump_valid !== 1'b0 || dbg_state !== ST_DONE) begin
      n_fail++;
      $display("FAIL dump_done_pulse: done=%b valid=%b state=%0d, required 1/0/DONE",
               dump_done, dump_valid, dbg_state);
    end
    tick();
    n_tests++;
    if (dump_done !== 1'b0 || dump_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL dump_after_done: done=%b valid=%b state=%0d, required 0/0/IDLE",
               dump_done, dump_valid, dbg_state);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp;
    dump_ready = 1'b1;
    start_dump();
    go_to_idx(5'd7);
    dump_ready = 1'b0;
    we3 = 1'b1; wa3 = 5'd7; wd3 = 64'h77;
    #1;
    n_tests++;
    if (dump_data !== 64'd21) begin
      n_fail++;
      $display("FAIL bp_no_bypass: data=%h, required 15", dump_data);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      we3 = 1'b0;
      #1;
      n_tests++;
      if (dump_valid !== 1'b1 || dump_idx !== 5'd7 || dump_data !== 64'h77) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid=%b idx=%0d data=%h, required 1/7/77",
                 k, dump_valid, dump_idx, dump_data);
      end
    end
    dump_ready = 1'b1;
    for (int b = 7; b < 32; b++) begin
      exp = (b == 31) ? 64'd0 : ((b == 7) ? 64'h77 : 64'(b * 3));
      n_tests++;
      if (dump_valid !== 1'b1 || dump_idx !== 5'(b) || dump_data !== exp) begin
        n_fail++;
        $display("FAIL bp_beat[%0d]: valid=%b idx=%0d data=%h, required 1/%0d/%h",
                 b, dump_valid, dump_idx, dump_data, b, exp);
      end
      tick();
    end
    n_tests++;
    if (dump_done !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_done: done=%b, required 1", dump_done);
    end
    tick();
  endtask

  task automatic test_reset_abort();
    dump_ready = 1'b1;
    start_dump();
    go_to_idx(5'd12);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_tests++;
    if (dump_valid !== 1'b0 || dbg_state !== ST_IDLE || dump_done !== 1'b0 || dump_idx !== 5'd0) begin
      n_fail++;
      $display("FAIL abort_state: valid=%b state=%0d done=%b idx=%0d, required 0/IDLE/0/0",
               dump_valid, dbg_state, dump_done, dump_idx);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (dump_done !== 1'b0 || dump_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_quiet[%0d]: done=%b valid=%b, required 0/0", k, dump_done, dump_valid);
      end
    end
    for (int a = 0; a < 31; a++) begin
      ra1 = 5'(a);
      #1;
      n_tests++;
      if (rd1 !== 64'd0) begin
        n_fail++;
        $display("FAIL abort_reg[%0d]: rd1=%h, required 0", a, rd1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_xzr();
    test_full_dump();
    test_backpressure();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The block SHALL have parameter N, default 64, giving the register data width.
REQ-002 The block SHALL have parameter REGS, default 32, giving the register count; index 31 is XZR.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, synchronous, active-high reset.
REQ-005 The block SHALL have ports ra1 and ra2, input, 5 bits each, the read addresses for ports 1 and 2.
REQ-006 The block SHALL have ports rd1 and rd2, output, N bits each, the read data for ports 1 and 2.
REQ-007 The block SHALL have port we3, input, 1 bit, the write enable.
REQ-008 The block SHALL have port wa3, input, 5 bits, the write address.
REQ-009 The block SHALL have port wd3, input, N bits, the write data.
REQ-010 The block SHALL have port dump_req, input, 1 bit, a request to stream out all registers.
REQ-011 The block SHALL have port dump_valid, output, 1 bit, indicating dump_data/dump_idx are valid.
REQ-012 The block SHALL have port dump_ready, input, 1 bit, the consumer-accepts signal.
REQ-013 The block SHALL have ports dump_idx, output, 5 bits, and dump_data, output, N bits, giving the register index and value being streamed.
REQ-014 The block SHALL have port dump_done, output, 1 bit, a one-cycle pulse after the last beat.

Function
REQ-015 Reads SHALL be combinational: rd1 = X[ra1] and rd2 = X[ra2].
REQ-016 A read of address 31 SHALL return 0, regardless of any write.
REQ-017 When we3=1 and wa3!=31, X[wa3] SHALL take wd3 at the rising clk edge; a write to 31 SHALL be discarded.
REQ-018 Write-through bypass: when we3=1, wa3!=31 and wa3==ra1 in the same cycle, rd1 SHALL equal wd3; the same rule applies to rd2 and ra2.
REQ-019 The dump FSM SHALL have the states IDLE, STREAM and DONE.
REQ-020 IDLE: with dump_req=1, the FSM SHALL go to STREAM and set dump_idx to 0; otherwise it SHALL hold.
REQ-021 STREAM: dump_valid SHALL be 1 and dump_data SHALL equal stored X[dump_idx] (0 when dump_idx=31), with no bypass.
REQ-022 STREAM: when dump_valid && dump_ready, dump_idx SHALL increment; at dump_idx=31 the FSM SHALL go to DONE instead.
REQ-023 STREAM: while dump_ready=0, dump_idx and dump_valid SHALL hold, and dump_data SHALL track any write to the held index.
REQ-024 DONE: dump_done=1 for exactly one cycle, then the FSM SHALL return to IDLE; dump_valid SHALL be 0.
REQ-025 dump_req asserted outside IDLE SHALL be ignored; a dump is exactly 32 beats, with indices 0..31 in order.
REQ-026 Register writes SHALL proceed unaffected during a dump.

Reset
REQ-027 On reset=1 at a rising edge, X[0..30] SHALL be 0, the FSM SHALL be IDLE, dump_idx=0, dump_valid=0 and dump_done=0.
REQ-028 Reset SHALL override a simultaneous we3 and dump_req.
REQ-029 Reset mid-dump SHALL abort the dump without a dump_done pulse.

Structure
REQ-030 A shared package regfile_pkg SHALL hold N, REGS, XZR_IDX=31 and the dump state enum.
REQ-031 The dump FSM and index counter SHALL be a sub-module regfile_dump_ctrl; the array, read muxes and bypass SHALL remain in regfile.

Verification
REQ-032 The bench SHALL check reset persistence: reset high for 5 cycles, then ra1=0..30 -> rd1=0 for every address.
REQ-033 The bench SHALL check write/read: we3=1, wa3=5, wd3=64'hDEAD_BEEF_0000_0001 -> rd1 shows it via bypass in the same cycle, and it persists after we3=0.
REQ-034 The bench SHALL check XZR: we3=1, wa3=31, wd3=64'hFFFF_FFFF_FFFF_FFFF -> rd2 with ra2=31 reads 0 in that cycle and the next.
REQ-035 The bench SHALL check a full dump: X[i]=i*3, dump_req pulse, dump_ready=1 -> 32 beats, idx 0..31 with data i*3 and beat 31 = 0, then one dump_done pulse.
REQ-036 The bench SHALL check backpressure: dump_ready=0 for 4 cycles at idx=7 while writing X[7]=64'h77 -> idx holds at 7, dump_data becomes 64'h77 the cycle after the write, and no beat is skipped.
REQ-037 The bench SHALL check reset abort: reset asserted at idx=12 -> next cycle dump_valid=0, FSM IDLE, no dump_done, and X[0..30]=0.
